// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported memory between an instruction-fetch requester (I)
// and a data requester (D). One transaction is in flight at a time. The memory
// strobes are driven for one cycle, the read latency is waited out, and then
// a completion pulse goes back to the owner.
//
// Ports
//   clk_i, rst_ni                  clock, async active-low reset
//   i_req_i, i_addr_i              fetch request / address
//   i_gnt_o, i_rvalid_o, i_rdata_o fetch grant, completion pulse, data
//   d_req_i, d_we_i, d_be_i,
//   d_addr_i, d_wdata_i            data request and write fields
//   d_gnt_o, d_rvalid_o, d_rdata_o data grant, completion pulse, data
//   m_csn_o, m_wen_o, m_be_o,
//   m_addr_o, m_dout_o, m_din_i    memory strobes (active-low) and buses
//   i_grants_o, d_grants_o         16-bit wrapping grant counters
//
// state  | meaning
// IDLE   | arbitrate, grant is combinational from the requests
// ACCESS | memory strobe cycle, latency counter loaded
// WAIT   | count down read latency, sample m_din_i on the last cycle
// RESP   | completion pulse to the owner
module mem_port_arbiter #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              i_req_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic              i_gnt_o,
    output logic              i_rvalid_o,
    output logic [DATA_W-1:0] i_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [3:0]        d_be_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              m_csn_o,
    output logic              m_wen_o,
    output logic [3:0]        m_be_o,
    output logic [ADDR_W-1:0] m_addr_o,
    output logic [DATA_W-1:0] m_dout_o,
    input  logic [DATA_W-1:0] m_din_i,
    output logic [15:0]       i_grants_o,
    output logic [15:0]       d_grants_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_WAIT, ST_RESP} state_e;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;   // 1 = D owns the transaction
    logic                last_q, last_d;     // 1 = D was granted last
    logic                we_q, we_d;         // latched data write
    logic [2:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
    logic [3:0]          m_be_q, m_be_d;
    logic [DATA_W-1:0]   m_dout_q, m_dout_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic [15:0]         i_grants_q, i_grants_d;
    logic [15:0]         d_grants_q, d_grants_d;
    logic                gnt_i, gnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            we_q       <= 1'b0;
            cnt_q      <= '0;
            m_addr_q   <= '0;
            m_be_q     <= '0;
            m_dout_q   <= '0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
            i_grants_q <= '0;
            d_grants_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            we_q       <= we_d;
            cnt_q      <= cnt_d;
            m_addr_q   <= m_addr_d;
            m_be_q     <= m_be_d;
            m_dout_q   <= m_dout_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
            i_grants_q <= i_grants_d;
            d_grants_q <= d_grants_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        we_d       = we_q;
        cnt_d      = cnt_q;
        m_addr_d   = m_addr_q;
        m_be_d     = m_be_q;
        m_dout_d   = m_dout_q;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        i_grants_d = i_grants_q;
        d_grants_d = d_grants_q;
        gnt_i      = 1'b0;
        gnt_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // On a conflict the requester not granted last wins.
                gnt_i = i_req_i && (!d_req_i || last_q);
                gnt_d = d_req_i && (!i_req_i || !last_q);
                if (gnt_i || gnt_d) begin
                    state_d = ST_ACCESS;
                    owner_d = gnt_d;
                    last_d  = gnt_d;
                    we_d    = gnt_d && d_we_i;
                    // Memory buses are registered here so they show the
                    // latched transaction in ACCESS and hold afterwards.
                    m_addr_d = gnt_d ? d_addr_i : i_addr_i;
                    if (gnt_d && d_we_i) begin
                        m_be_d   = d_be_i;
                        m_dout_d = d_wdata_i;
                    end else begin
                        m_be_d   = 4'b1111;
                    end
                    if (gnt_d) d_grants_d = d_grants_q + 16'd1;
                    else       i_grants_d = i_grants_q + 16'd1;
                end
            end
            ST_ACCESS: begin
                cnt_d   = 3'(MEM_LAT);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == 3'd1) begin
                    state_d = ST_RESP;
                    if (!we_q) begin
                        if (owner_q) d_rdata_d = m_din_i;
                        else         i_rdata_d = m_din_i;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign i_gnt_o    = gnt_i;
    assign d_gnt_o    = gnt_d;
    assign i_rvalid_o = (state_q == ST_RESP) && !owner_q;
    assign d_rvalid_o = (state_q == ST_RESP) && owner_q;
    assign i_rdata_o  = i_rdata_q;
    assign d_rdata_o  = d_rdata_q;
    assign m_csn_o    = (state_q != ST_ACCESS);
    assign m_wen_o    = !((state_q == ST_ACCESS) && we_q);
    assign m_be_o     = m_be_q;
    assign m_addr_o   = m_addr_q;
    assign m_dout_o   = m_dout_q;
    assign i_grants_o = i_grants_q;
    assign d_grants_o = d_grants_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter. Stimulus pushes the expected completion
// (owner, data, cycle) into a queue; a monitor pops and compares on each
// RVALID. A second instance with MEM_LAT=4 checks the longer latency timing.
module tb_mem_port_arbiter;

    typedef struct {
        bit          own_d;
        logic [31:0] data;
        int          cyc;
    } sb_item_t;

    logic        clk, rst_n;
    logic        i_req, i_gnt, i_rvalid;
    logic [11:0] i_addr;
    logic [31:0] i_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [3:0]  d_be;
    logic [11:0] d_addr;
    logic [31:0] d_wdata, d_rdata;
    logic        m_csn, m_wen;
    logic [3:0]  m_be;
    logic [11:0] m_addr;
    logic [31:0] m_dout, m_din;
    logic [15:0] i_grants, d_grants;

    logic        d4_i_req, d4_i_gnt, d4_i_rvalid;
    logic [11:0] d4_i_addr;
    logic [31:0] d4_i_rdata;
    logic        d4_req, d4_we, d4_gnt, d4_rvalid;
    logic [3:0]  d4_be;
    logic [11:0] d4_addr;
    logic [31:0] d4_wdata, d4_rdata;
    logic        d4_csn, d4_wen;
    logic [3:0]  d4_mbe;
    logic [11:0] d4_maddr;
    logic [31:0] d4_dout, d4_din;
    logic [15:0] d4_igr, d4_dgr;

    int          tests = 0;
    int          failures = 0;
    int          cyc = 0;
    sb_item_t    sb[$];
    logic [31:0] exp_i_rdata = 0, exp_d_rdata = 0;
    int          exp_i_cnt = 0, exp_d_cnt = 0;
    bit          exp_last = 1'b1;

    mem_port_arbiter #(.ADDR_W(12), .DATA_W(32), .MEM_LAT(1)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .i_req_i(i_req), .i_addr_i(i_addr), .i_gnt_o(i_gnt),
        .i_rvalid_o(i_rvalid), .i_rdata_o(i_rdata),
        .d_req_i(d_req), .d_we_i(d_we), .d_be_i(d_be), .d_addr_i(d_addr),
        .d_wdata_i(d_wdata), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid),
        .d_rdata_o(d_rdata),
        .m_csn_o(m_csn), .m_wen_o(m_wen), .m_be_o(m_be), .m_addr_o(m_addr),
        .m_dout_o(m_dout), .m_din_i(m_din),
        .i_grants_o(i_grants), .d_grants_o(d_grants)
    );

    mem_port_arbiter #(.ADDR_W(12), .DATA_W(32), .MEM_LAT(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n),
        .i_req_i(d4_i_req), .i_addr_i(d4_i_addr), .i_gnt_o(d4_i_gnt),
        .i_rvalid_o(d4_i_rvalid), .i_rdata_o(d4_i_rdata),
        .d_req_i(d4_req), .d_we_i(d4_we), .d_be_i(d4_be), .d_addr_i(d4_addr),
        .d_wdata_i(d4_wdata), .d_gnt_o(d4_gnt), .d_rvalid_o(d4_rvalid),
        .d_rdata_o(d4_rdata),
        .m_csn_o(d4_csn), .m_wen_o(d4_wen), .m_be_o(d4_mbe), .m_addr_o(d4_maddr),
        .m_dout_o(d4_dout), .m_din_i(d4_din),
        .i_grants_o(d4_igr), .d_grants_o(d4_dgr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor for the MEM_LAT=1 instance.
    always @(negedge clk) begin
        if (rst_n) begin
            if (i_gnt || d_gnt) chk("gnt_exclusive", {31'd0, i_gnt & d_gnt}, 32'd0);
            if (i_rvalid || d_rvalid) begin
                chk("rvalid_exclusive", {31'd0, i_rvalid & d_rvalid}, 32'd0);
                if (sb.size() == 0) begin
                    chk("unexpected_rvalid", {31'd0, d_rvalid}, {31'd0, ~d_rvalid});
                end else begin
                    sb_item_t it;
                    it = sb.pop_front();
                    chk("rvalid_owner", {31'd0, d_rvalid}, {31'd0, it.own_d});
                    chk("rvalid_cycle", cyc, it.cyc);
                    chk("rdata", it.own_d ? d_rdata : i_rdata, it.data);
                end
            end
        end
    end

    task automatic check_reset();
        chk("rst_csn", {31'd0, m_csn}, 32'd1);
        chk("rst_wen", {31'd0, m_wen}, 32'd1);
        chk("rst_gnt", {30'd0, i_gnt, d_gnt}, 32'd0);
        chk("rst_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);
        chk("rst_m_be", {28'd0, m_be}, 32'd0);
        chk("rst_m_addr", {20'd0, m_addr}, 32'd0);
        chk("rst_m_dout", m_dout, 32'd0);
        chk("rst_i_rdata", i_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_i_grants", {16'd0, i_grants}, 32'd0);
        chk("rst_d_grants", {16'd0, d_grants}, 32'd0);
    endtask

    // Single-requester transaction on the MEM_LAT=1 instance. Called just
    // after a rising edge; returns just after the rising edge into IDLE.
    task automatic txn(input bit own_d, input bit we, input logic [3:0] be,
                       input logic [11:0] addr, input logic [31:0] wdata,
                       input logic [31:0] din);
        sb_item_t it;
        bit       got;
        bit       wr;
        wr = own_d && we;
        if (own_d) begin
            d_req = 1'b1; d_we = we; d_be = be; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = own_d ? d_gnt : i_gnt;
        end
        if (!got) begin
            chk("grant_timeout", 32'd0, 32'd1);
            i_req = 1'b0; d_req = 1'b0;
            return;
        end
        chk("other_gnt_low", {31'd0, own_d ? i_gnt : d_gnt}, 32'd0);
        if (!wr) begin
            if (own_d) exp_d_rdata = din;
            else       exp_i_rdata = din;
        end
        it.own_d = own_d;
        it.data  = own_d ? exp_d_rdata : exp_i_rdata;
        it.cyc   = cyc + 3;
        sb.push_back(it);
        if (own_d) exp_d_cnt++; else exp_i_cnt++;
        exp_last = own_d;
        @(posedge clk); #1;
        // Requests dropped and fields scrambled: the latched values must stick.
        i_req = 1'b0; d_req = 1'b0;
        i_addr = ~addr; d_addr = ~addr; d_be = ~be; d_wdata = ~wdata; d_we = ~we;
        m_din = wr ? 32'hBAD0_BAD0 : din;
        @(negedge clk);
        chk("acc_csn", {31'd0, m_csn}, 32'd0);
        chk("acc_wen", {31'd0, m_wen}, {31'd0, !wr});
        chk("acc_be", {28'd0, m_be}, {28'd0, wr ? be : 4'hF});
        chk("acc_addr", {20'd0, m_addr}, {20'd0, addr});
        if (wr) chk("acc_dout", m_dout, wdata);
        @(negedge clk);
        chk("wait_csn", {31'd0, m_csn}, 32'd1);
        chk("wait_addr_hold", {20'd0, m_addr}, {20'd0, addr});
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        bit got;
        sb_item_t it;
        rst_n = 1'b0;
        i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_be = 0; d_addr = 0;
        d_wdata = 0; m_din = 0;
        d4_i_req = 0; d4_i_addr = 0; d4_req = 0; d4_we = 0; d4_be = 0;
        d4_addr = 0; d4_wdata = 0; d4_din = 0;

        repeat (3) @(negedge clk);
        check_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic reads and writes on the MEM_LAT=1 instance.
        txn(1'b0, 1'b0, 4'h0,    12'h010, 32'h0,         32'hDEAD_BEEF);
        chk("i_grants_1", {16'd0, i_grants}, 32'd1);
        txn(1'b1, 1'b1, 4'b0011, 12'h020, 32'h1234_5678, 32'h0);
        txn(1'b1, 1'b0, 4'h0,    12'h021, 32'h0,         32'h0BAD_F00D);
        txn(1'b1, 1'b1, 4'b0000, 12'h022, 32'hFFFF_0000, 32'h0);
        txn(1'b1, 1'b0, 4'h0,    12'hFFF, 32'h0,         32'h1357_9BDF);
        chk("i_grants_after_basic", {16'd0, i_grants}, 32'd1);
        chk("d_grants_after_basic", {16'd0, d_grants}, 32'd4);

        // Both held for four transactions: I, D, I, D.
        i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; i_addr = 12'h0C0; d_addr = 12'h0D0;
        m_din = 32'hA000_0000;
        for (int n = 0; n < 4; n++) begin
            got = 1'b0;
            for (int k = 0; k < 20 && !got; k++) begin
                @(negedge clk);
                got = i_gnt | d_gnt;
            end
            if (!got) begin
                chk("rr_grant_timeout", 32'd0, 32'd1);
                break;
            end
            chk("rr_owner", {31'd0, d_gnt}, n % 2);
            it.own_d = d_gnt;
            it.data  = m_din;
            it.cyc   = cyc + 3;
            sb.push_back(it);
            if (d_gnt) begin exp_d_rdata = m_din; exp_d_cnt++; end
            else       begin exp_i_rdata = m_din; exp_i_cnt++; end
            exp_last = d_gnt;
            @(posedge clk); #1;
            if (n == 3) begin i_req = 1'b0; d_req = 1'b0; end
            repeat (2) @(posedge clk);
            #1;
            m_din = m_din + 32'd1;
        end
        repeat (4) @(posedge clk);
        #1;
        chk("rr_i_grants", {16'd0, i_grants}, 32'd3);
        chk("rr_d_grants", {16'd0, d_grants}, 32'd6);
        chk("rr_i_grants_model", {16'd0, i_grants}, exp_i_cnt);
        chk("rr_d_grants_model", {16'd0, d_grants}, exp_d_cnt);

        // Reset during WAIT aborts the transaction without a completion.
        d_req = 1'b1; d_we = 1'b0; d_addr = 12'h0AA;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = d_gnt;
        end
        chk("abort_grant", {31'd0, got}, 32'd1);
        @(posedge clk); #1;
        d_req = 1'b0; m_din = 32'h5555_5555;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset();
        exp_i_rdata = 0; exp_d_rdata = 0; exp_i_cnt = 0; exp_d_cnt = 0; exp_last = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        m_din = 32'h600D_CAFE;
        i_req = 1'b1; d_req = 1'b1; i_addr = 12'h100; d_addr = 12'h200;
        @(negedge clk);
        chk("post_rst_i_wins", {31'd0, i_gnt}, 32'd1);
        chk("post_rst_d_waits", {31'd0, d_gnt}, 32'd0);
        if (i_gnt) begin
            it.own_d = 1'b0;
            it.data  = 32'h600D_CAFE;
            it.cyc   = cyc + 3;
            sb.push_back(it);
        end
        @(posedge clk); #1;
        i_req = 1'b0; d_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("post_rst_i_grants", {16'd0, i_grants}, 32'd1);
        chk("post_rst_d_grants", {16'd0, d_grants}, 32'd0);

        // MEM_LAT=4: completion 6 cycles after the grant edge, a request
        // raised during WAIT is granted only back in IDLE (cycle 7).
        d4_req = 1'b1; d4_we = 1'b0; d4_addr = 12'h055; d4_din = 32'hCAFE_F00D;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = d4_gnt;
        end
        chk("lat4_grant", {31'd0, got}, 32'd1);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (k == 1) d4_req = 1'b0;
            if (k == 3) d4_req = 1'b1;
            if (k == 8) d4_req = 1'b0;
            @(negedge clk);
            chk("lat4_rvalid", {31'd0, d4_rvalid}, {31'd0, k == 6});
            chk("lat4_gnt", {31'd0, d4_gnt}, {31'd0, k == 7});
            if (k == 1) chk("lat4_acc_csn", {31'd0, d4_csn}, 32'd0);
            if (k == 2) chk("lat4_wait_csn", {31'd0, d4_csn}, 32'd1);
            if (k == 6) chk("lat4_rdata", d4_rdata, 32'hCAFE_F00D);
        end
        repeat (8) @(posedge clk);
        #1;
        chk("lat4_d_grants", {16'd0, d4_dgr}, 32'd2);
        chk("sb_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
